// File: rtl/spi_master.sv
// SPI master, CPOL=0 / CPHA=0, one byte per transfer, MSB first.
// The SCK half-period is HALF_PERIOD system clocks; the select is released one half-period after the last SCK fall.
module spi_master #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       mosi,
  output logic       sck,
  output logic       ss,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic [1:0] dbg_state
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_sample;
  logic             r_miso;
  logic             w_div_wrap;

  assign w_div_wrap = (r_div == DIV_LAST);
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'h00;
      r_sample <= 1'b0;
      r_miso   <= 1'b0;
      mosi     <= 1'b0;
      sck      <= 1'b0;
      ss       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= 8'h00;
    end else begin
      // miso is asynchronous; this single register is its only synchroniser
      r_miso <= miso;
      done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ACTIVE;
            r_shift <= din;
            mosi    <= din[7];
            ss      <= 1'b0;
            busy    <= 1'b1;
            r_bit   <= 3'd0;
            r_div   <= '0;
          end
        end
        ACTIVE: begin
          if (w_div_wrap) begin
            r_div <= '0;
            sck   <= ~sck;
            if (!sck) begin
              r_sample <= r_miso;
            end else begin
              // falling edge: shift in the sampled bit and present the next MSB
              r_shift <= {r_shift[6:0], r_sample};
              mosi    <= r_shift[6];
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_state <= HOLD;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        HOLD: begin
          if (w_div_wrap) begin
            r_div   <= '0;
            r_state <= IDLE;
            ss      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            dout    <= r_shift;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a fast (HALF_PERIOD=4) and a slow (HALF_PERIOD=255) instance,
// each with a behavioural CPOL0/CPHA0 slave and an edge monitor.
module tb_spi_master;

  localparam int HP0 = 4;
  localparam int HP1 = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       t_rst[2];
  logic       t_start[2];
  logic       t_miso[2];
  logic [7:0] t_din[2];
  logic       t_mosi[2];
  logic       t_sck[2];
  logic       t_ss[2];
  logic       t_busy[2];
  logic       t_done[2];
  logic [7:0] t_dout[2];
  logic [1:0] t_dbg[2];

  spi_master #(.HALF_PERIOD(HP0)) u_fast (
    .clk(clk), .rst(t_rst[0]), .start(t_start[0]), .din(t_din[0]), .miso(t_miso[0]),
    .mosi(t_mosi[0]), .sck(t_sck[0]), .ss(t_ss[0]), .busy(t_busy[0]), .done(t_done[0]),
    .dout(t_dout[0]), .dbg_state(t_dbg[0])
  );

  spi_master #(.HALF_PERIOD(HP1)) u_slow (
    .clk(clk), .rst(t_rst[1]), .start(t_start[1]), .din(t_din[1]), .miso(t_miso[1]),
    .mosi(t_mosi[1]), .sck(t_sck[1]), .ss(t_ss[1]), .busy(t_busy[1]), .done(t_done[1]),
    .dout(t_dout[1]), .dbg_state(t_dbg[1])
  );

  int hp[2] = '{HP0, HP1};
  int n_chk = 0;
  int n_pass = 0;

  // Monitor and slave state, owned by the negedge process below
  int         rises[2]    = '{0, 0};
  int         dones[2]    = '{0, 0};
  int         bad_w[2]    = '{0, 0};
  int         unst[2]     = '{0, 0};
  int         viol[2]     = '{0, 0};
  int         run[2]      = '{0, 0};
  int         scnt[2]     = '{0, 0};
  logic       psck[2]     = '{1'b0, 1'b0};
  logic       pmosi[2]    = '{1'b0, 1'b0};
  logic       lastfall[2] = '{1'b0, 1'b0};
  logic [7:0] mbits[2]    = '{8'h00, 8'h00};

  // Written by the stimulus process only
  logic [7:0] sbyte[2];
  logic       loopb[2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (t_sck[g] !== psck[g]) begin
        if (psck[g]) begin
          if (run[g] != hp[g]) bad_w[g]++;
          lastfall[g] = 1'b1;
          if (!t_ss[g]) scnt[g]++;
        end else begin
          if (lastfall[g] && run[g] != hp[g]) bad_w[g]++;
          rises[g]++;
          mbits[g] = {mbits[g][6:0], t_mosi[g]};
          if (t_mosi[g] !== pmosi[g]) unst[g]++;
        end
        run[g] = 1;
      end else begin
        run[g]++;
      end
      if (t_ss[g]) begin
        scnt[g]     = 0;
        lastfall[g] = 1'b0;
      end
      if (t_sck[g] && t_ss[g]) viol[g]++;
      if (t_done[g]) dones[g]++;
      psck[g]  = t_sck[g];
      pmosi[g] = t_mosi[g];
      t_miso[g] = loopb[g] ? t_mosi[g] : sbyte[g][7 - (scnt[g] % 8)];
    end
  end

  // Starts at a negedge with the instance idle; returns the cycle (T+n) in which done was seen.
  // poke_at > 0 pulses start with din=8'h11 in cycle T+poke_at.
  task automatic xfer(input int g, input logic [7:0] tx, input int poke_at, output int lat);
    t_din[g]   = tx;
    t_start[g] = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    t_start[g] = 1'b0;
    while (!t_done[g] && lat < 10000) begin
      if (lat == poke_at) begin
        t_start[g] = 1'b1;
        t_din[g]   = 8'h11;
      end else begin
        t_start[g] = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    t_start[g] = 1'b0;
  endtask

  task automatic test_reset();
    t_rst[0] = 1'b1; t_rst[1] = 1'b1;
    t_start[0] = 1'b1; t_din[0] = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (t_ss[0] !== 1'b1)    $display("FAIL reset_ss: got %b exp 1", t_ss[0]); else n_pass++;
    n_chk++; if (t_sck[0] !== 1'b0)   $display("FAIL reset_sck: got %b exp 0", t_sck[0]); else n_pass++;
    n_chk++; if (t_mosi[0] !== 1'b0)  $display("FAIL reset_mosi: got %b exp 0", t_mosi[0]); else n_pass++;
    n_chk++; if (t_busy[0] !== 1'b0)  $display("FAIL reset_busy_prio: got %b exp 0", t_busy[0]); else n_pass++;
    n_chk++; if (t_done[0] !== 1'b0)  $display("FAIL reset_done: got %b exp 0", t_done[0]); else n_pass++;
    n_chk++; if (t_dout[0] !== 8'h00) $display("FAIL reset_dout: got %h exp 00", t_dout[0]); else n_pass++;
    n_chk++; if (t_dbg[0] !== 2'd0)   $display("FAIL reset_state: got %0d exp 0", t_dbg[0]); else n_pass++;
    n_chk++; if (t_ss[1] !== 1'b1)    $display("FAIL reset_slow_ss: got %b exp 1", t_ss[1]); else n_pass++;
    t_rst[0] = 1'b0; t_rst[1] = 1'b0;
    t_start[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (t_sck[0] !== 1'b0 || t_ss[0] !== 1'b1 || t_done[0] !== 1'b0 || t_dout[0] !== 8'h00) bad++;
      @(negedge clk);
    end
    n_chk++; if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles exp 0", bad); else n_pass++;
  endtask

  task automatic test_basic();
    int lat, r0, v0;
    sbyte[0] = 8'h3C;
    r0 = rises[0]; v0 = viol[0];
    xfer(0, 8'hA5, 0, lat);
    n_chk++; if (lat !== 69)          $display("FAIL basic_latency: got %0d exp 69", lat); else n_pass++;
    n_chk++; if (t_dout[0] !== 8'h3C) $display("FAIL basic_dout: got %h exp 3c", t_dout[0]); else n_pass++;
    n_chk++; if (mbits[0] !== 8'hA5)  $display("FAIL basic_mosi_bits: got %h exp a5", mbits[0]); else n_pass++;
    n_chk++; if (rises[0] - r0 !== 8) $display("FAIL basic_rises: got %0d exp 8", rises[0] - r0); else n_pass++;
    n_chk++; if (t_ss[0] !== 1'b1 || t_busy[0] !== 1'b0)
      $display("FAIL basic_done_cycle: got ss=%b busy=%b exp ss=1 busy=0", t_ss[0], t_busy[0]); else n_pass++;
    n_chk++; if (viol[0] - v0 !== 0)  $display("FAIL basic_sck_while_ss: got %0d exp 0", viol[0] - v0); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ignore();
    int lat, d0, busy_hi;
    sbyte[0] = 8'h5A;
    d0 = dones[0];
    xfer(0, 8'hC3, 10, lat);
    busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (t_busy[0] !== 1'b0 || t_ss[0] !== 1'b1) busy_hi++;
    end
    n_chk++; if (lat !== 69)          $display("FAIL ignore_latency: got %0d exp 69", lat); else n_pass++;
    n_chk++; if (t_dout[0] !== 8'h5A) $display("FAIL ignore_dout: got %h exp 5a", t_dout[0]); else n_pass++;
    n_chk++; if (mbits[0] !== 8'hC3)  $display("FAIL ignore_mosi_bits: got %h exp c3", mbits[0]); else n_pass++;
    n_chk++; if (busy_hi !== 0)       $display("FAIL ignore_no_queue: got %0d busy cycles exp 0", busy_hi); else n_pass++;
    n_chk++; if (dones[0] - d0 !== 1) $display("FAIL ignore_one_done: got %0d exp 1", dones[0] - d0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n, nd, busy_lo, ss_hi;
    logic [7:0] got[2];
    loopb[0] = 1'b1;
    got[0] = 8'hxx; got[1] = 8'hxx;
    t_din[0] = 8'h00; t_start[0] = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    t_din[0] = 8'hFF;
    nd = 0; busy_lo = 0; ss_hi = 0;
    while (nd < 2 && n < 1000) begin
      if (t_busy[0] === 1'b0) busy_lo++;
      if (t_ss[0] === 1'b1) ss_hi++;
      if (t_done[0] === 1'b1) begin
        got[nd] = t_dout[0];
        nd++;
      end else if (nd == 1) begin
        t_start[0] = 1'b0;
      end
      if (nd < 2) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
    end
    t_start[0] = 1'b0;
    loopb[0] = 1'b0;
    n_chk++; if (got[0] !== 8'h00) $display("FAIL b2b_dout0: got %h exp 00", got[0]); else n_pass++;
    n_chk++; if (got[1] !== 8'hFF) $display("FAIL b2b_dout1: got %h exp ff", got[1]); else n_pass++;
    n_chk++; if (n !== 138)        $display("FAIL b2b_second_done: got T+%0d exp T+138", n); else n_pass++;
    n_chk++; if (busy_lo !== 2)    $display("FAIL b2b_busy_low: got %0d exp 2", busy_lo); else n_pass++;
    n_chk++; if (ss_hi !== 2)      $display("FAIL b2b_ss_high: got %0d exp 2", ss_hi); else n_pass++;
    @(negedge clk);
    n_chk++; if (t_busy[0] !== 1'b0) $display("FAIL b2b_no_third: got busy=%b exp 0", t_busy[0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, d0;
    sbyte[0] = 8'hAA;
    t_din[0] = 8'hF0; t_start[0] = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    t_start[0] = 1'b0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_chk++; if (t_busy[0] !== 1'b1) $display("FAIL rmid_busy_before: got %b exp 1", t_busy[0]); else n_pass++;
    d0 = dones[0];
    t_rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_rst[0] = 1'b0;
    n_chk++; if (t_ss[0] !== 1'b1)    $display("FAIL rmid_ss: got %b exp 1", t_ss[0]); else n_pass++;
    n_chk++; if (t_sck[0] !== 1'b0)   $display("FAIL rmid_sck: got %b exp 0", t_sck[0]); else n_pass++;
    n_chk++; if (t_busy[0] !== 1'b0)  $display("FAIL rmid_busy: got %b exp 0", t_busy[0]); else n_pass++;
    n_chk++; if (t_dout[0] !== 8'h00) $display("FAIL rmid_dout: got %h exp 00", t_dout[0]); else n_pass++;
    repeat (100) @(negedge clk);
    n_chk++; if (dones[0] - d0 !== 0) $display("FAIL rmid_no_done: got %0d exp 0", dones[0] - d0); else n_pass++;
    sbyte[0] = 8'h96;
    xfer(0, 8'h3C, 0, lat);
    n_chk++; if (lat !== 69)          $display("FAIL rmid_after_latency: got %0d exp 69", lat); else n_pass++;
    n_chk++; if (t_dout[0] !== 8'h96) $display("FAIL rmid_after_dout: got %h exp 96", t_dout[0]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, r0, w0, u0, v0;
    logic [7:0] tx, sb;
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 2; k++) begin
        tx = 8'($urandom_range(0, 255));
        sb = 8'($urandom_range(0, 255));
        sbyte[g] = sb;
        r0 = rises[g]; w0 = bad_w[g]; u0 = unst[g]; v0 = viol[g];
        xfer(g, tx, 0, lat);
        n_chk++; if (t_dout[g] !== sb) $display("FAIL rand%0d_dout: got %h exp %h", g, t_dout[g], sb); else n_pass++;
        n_chk++; if (mbits[g] !== tx)  $display("FAIL rand%0d_mosi_bits: got %h exp %h", g, mbits[g], tx); else n_pass++;
        n_chk++; if (lat !== 1 + 17 * hp[g]) $display("FAIL rand%0d_latency: got %0d exp %0d", g, lat, 1 + 17 * hp[g]); else n_pass++;
        n_chk++; if (rises[g] - r0 !== 8) $display("FAIL rand%0d_rises: got %0d exp 8", g, rises[g] - r0); else n_pass++;
        n_chk++; if (bad_w[g] - w0 !== 0) $display("FAIL rand%0d_sck_width: got %0d bad exp 0", g, bad_w[g] - w0); else n_pass++;
        n_chk++; if (unst[g] - u0 !== 0)  $display("FAIL rand%0d_mosi_stable: got %0d bad exp 0", g, unst[g] - u0); else n_pass++;
        n_chk++; if (viol[g] - v0 !== 0)  $display("FAIL rand%0d_sck_while_ss: got %0d exp 0", g, viol[g] - v0); else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    t_rst[0] = 1'b1;   t_rst[1] = 1'b1;
    t_start[0] = 1'b0; t_start[1] = 1'b0;
    t_din[0] = 8'h00;  t_din[1] = 8'h00;
    sbyte[0] = 8'h00;  sbyte[1] = 8'h00;
    loopb[0] = 1'b0;   loopb[1] = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_basic();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
